// File: rtl/pipeline_fifo.sv
// Show-ahead synchronous FIFO that absorbs a stall-free pipeline stream and flags dropped words.
// Optional occupancy output o_level is enabled by defining PIPELINE_FIFO_LEVEL_EN.
module pipeline_fifo #(
  parameter int p_width = 32,
  parameter int p_depth = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [p_width-1:0] i_data,
  output logic               o_ready,
  output logic               o_valid,
  output logic [p_width-1:0] o_data,
  input  logic               i_ready,
  output logic               o_overflow
`ifdef PIPELINE_FIFO_LEVEL_EN
  ,
  output logic [$clog2(p_depth):0] o_level
`endif
);

  localparam int p_aw = $clog2(p_depth);
  localparam logic [p_aw:0] ptr_one = 1;

  // Handshake: a word moves on a side only in a cycle where its valid and ready
  // are both high at the rising edge. o_ready and o_valid depend only on
  // registered pointers, never on i_valid or i_ready.

  logic [p_width-1:0] mem [p_depth];
  logic [p_aw:0]      wr_ptr;
  logic [p_aw:0]      rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // The extra MSB separates a full buffer from an empty one when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[p_aw] != rd_ptr[p_aw]) &&
                 (wr_ptr[p_aw-1:0] == rd_ptr[p_aw-1:0]);

  assign push = i_valid && !full;
  assign pop  = !empty && i_ready;

  assign o_ready = !full;
  assign o_valid = !empty;
  assign o_data  = empty ? '0 : mem[rd_ptr[p_aw-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (pop)  rd_ptr <= rd_ptr + ptr_one;
    end
  end

  // Storage is deliberately left unreset; o_data masks it while empty.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) mem[wr_ptr[p_aw-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                o_overflow <= 1'b0;
    else if (i_valid && full) o_overflow <= 1'b1;
  end

`ifdef PIPELINE_FIFO_LEVEL_EN
  assign o_level = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_pipeline_fifo.sv
// Bench for pipeline_fifo: directed vector table, hand-written corner sequences and
// random traffic checked against a queue-based model. Honours PIPELINE_FIFO_LEVEL_EN.
module tb_pipeline_fifo;
  localparam int W = 32;
  localparam int D = 4;
  localparam int LW = $clog2(D) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_valid = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          i_ready = 1'b0;
  logic          o_ready;
  logic          o_valid;
  logic [W-1:0]  o_data;
  logic          o_overflow;
`ifdef PIPELINE_FIFO_LEVEL_EN
  logic [LW-1:0] o_level;
`endif

  pipeline_fifo #(.p_width(W), .p_depth(D)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_valid(i_valid),
    .i_data(i_data),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data(o_data),
    .i_ready(i_ready),
    .o_overflow(o_overflow)
`ifdef PIPELINE_FIFO_LEVEL_EN
    ,
    .o_level(o_level)
`endif
  );

  // clock / reset block
  always #5 i_clk = ~i_clk;

  // scoreboard: expected queue of stored words plus sticky overflow
  logic [W-1:0] exp_q[$];
  logic         exp_ovf = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  typedef struct {
    logic         rst;
    logic         valid;
    logic [W-1:0] data;
    logic         ready;
    logic         e_valid;
    logic         e_ready;
    logic [W-1:0] e_data;
    logic         e_ovf;
    int           e_level;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // model update from the rules: reset wins; pop and push judged on pre-edge occupancy
  task automatic model_step(input logic rst, input logic valid, input logic [W-1:0] data,
                            input logic ready);
    int sz;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (sz > 0 && ready) void'(exp_q.pop_front());
      if (valid && sz < D) exp_q.push_back(data);
      if (valid && sz == D) exp_ovf = 1'b1;
    end
  endtask

  // driver: apply inputs for one cycle, advance model, sample #1 after the edge
  task automatic drive(input logic rst, input logic valid, input logic [W-1:0] data,
                       input logic ready);
    i_rst = rst;
    i_valid = valid;
    i_data = data;
    i_ready = ready;
    model_step(rst, valid, data, ready);
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".o_valid"}, W'(o_valid), W'(exp_q.size() > 0));
    check({tag, ".o_ready"}, W'(o_ready), W'(exp_q.size() < D));
    check({tag, ".o_data"}, o_data, (exp_q.size() > 0) ? exp_q[0] : '0);
    check({tag, ".o_overflow"}, W'(o_overflow), W'(exp_ovf));
`ifdef PIPELINE_FIFO_LEVEL_EN
    check({tag, ".o_level"}, W'(o_level), W'(exp_q.size()));
`endif
  endtask

  task automatic add_vec(input logic rst, input logic valid, input logic [W-1:0] data,
                         input logic ready, input logic ev, input logic er,
                         input logic [W-1:0] ed, input logic eo, input int el);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.ready = ready;
    v.e_valid = ev; v.e_ready = er; v.e_data = ed; v.e_ovf = eo; v.e_level = el;
    vecs.push_back(v);
  endtask

  initial begin
    int pat[6];
    int k;
    // reset (with a competing push), fill with stall, hold, drain, ignored i_data
    add_vec(1, 0, 32'h0,    0, 0, 1, 32'h0,  0, 0);
    add_vec(1, 1, 32'hDEAD, 1, 0, 1, 32'h0,  0, 0);
    add_vec(0, 1, 32'h11,   0, 1, 1, 32'h11, 0, 1);
    add_vec(0, 1, 32'h22,   0, 1, 1, 32'h11, 0, 2);
    add_vec(0, 1, 32'h33,   0, 1, 1, 32'h11, 0, 3);
    add_vec(0, 1, 32'h44,   0, 1, 0, 32'h11, 0, 4);
    add_vec(0, 0, 32'h99,   0, 1, 0, 32'h11, 0, 4);
    add_vec(0, 0, 32'h0,    1, 1, 1, 32'h22, 0, 3);
    add_vec(0, 0, 32'h0,    1, 1, 1, 32'h33, 0, 2);
    add_vec(0, 0, 32'h0,    1, 1, 1, 32'h44, 0, 1);
    add_vec(0, 0, 32'h0,    1, 0, 1, 32'h0,  0, 0);
    add_vec(0, 0, 32'h55,   1, 0, 1, 32'h0,  0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].ready);
      check($sformatf("vec%0d.o_valid", i), W'(o_valid), W'(vecs[i].e_valid));
      check($sformatf("vec%0d.o_ready", i), W'(o_ready), W'(vecs[i].e_ready));
      check($sformatf("vec%0d.o_data", i), o_data, vecs[i].e_data);
      check($sformatf("vec%0d.o_overflow", i), W'(o_overflow), W'(vecs[i].e_ovf));
`ifdef PIPELINE_FIFO_LEVEL_EN
      check($sformatf("vec%0d.o_level", i), W'(o_level), W'(vecs[i].e_level));
`endif
    end

    // streaming: each word visible one cycle after its push, level stays <= 1
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, W'(i), 1);
      check_model("stream");
      check("stream.word", o_data, W'(i));
    end
    drive(0, 0, '0, 1);
    check_model("stream_end");

    // full with simultaneous push and pop: 0xFF dropped, overflow sticky
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, W'(32'hA0 + i), 0);
      check_model("fill_a");
    end
    drive(0, 1, 32'hFF, 1);
    check_model("full_pushpop");
    check("full_pushpop.head", o_data, 32'hA1);
    check("full_pushpop.ovf", W'(o_overflow), W'(1'b1));
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, '0, 1);
      check_model("drain_a");
    end
    check("drain_a.ovf_held", W'(o_overflow), W'(1'b1));

    // wrap-around: 11 words, irregular consumer pattern, push only when room
    pat = '{1, 0, 0, 1, 1, 0};
    k = 0;
    for (int c = 0; c < 60 && (k < 11 || exp_q.size() > 0); c++) begin
      logic v;
      v = (k < 11) && (exp_q.size() < D);
      drive(0, v, W'(32'hB0 + k), pat[c % 6] != 0);
      if (v) k++;
      check_model("wrap");
    end
    check("wrap.all_pushed", W'(k), W'(11));

    // reset mid-operation with concurrent push and pop
    for (int i = 0; i < 3; i++) drive(0, 1, W'(32'hC0 + i), 0);
    check_model("pre_rst");
    drive(1, 1, 32'hEE, 1);
    check_model("mid_rst");
    check("mid_rst.o_valid", W'(o_valid), W'(1'b0));
    check("mid_rst.o_overflow", W'(o_overflow), W'(1'b0));
    drive(0, 0, '0, 1);
    check_model("post_rst");

    // random traffic against the model, rare resets
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, W'($urandom),
            $urandom_range(0, 2) != 0);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
